// File: rtl/board_dump_uart_tx.sv
// Purpose : walk the game board through the debug readback port and stream it as ASCII text over UART 8N1.
// Latency : first start bit 3 clocks after start is accepted; each byte 10*BAUD_DIV clocks plus 3 idle clocks.
// Backpressure: none; start is ignored while busy (and in the done cycle), nothing is queued.
//
// Ports:
//   clk_25MHz, rst_n      clock, asynchronous active-low reset
//   start                 1-cycle dump request
//   d_piece_data          2-bit piece code returned for (d_r_row, d_r_col)
//   e_debug, read_board   debug enable / readback select toward the game top, high while dumping
//   d_r_row, d_r_col      readback address, held stable for the whole byte
//   uart_tx               serial line, idle high, LSB first
//   busy, done            dump in progress / 1-cycle completion pulse
module board_dump_uart_tx #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int BAUD_DIV = 217
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] d_piece_data,
  output logic       e_debug,
  output logic       read_board,
  output logic [2:0] d_r_row,
  output logic [2:0] d_r_col,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  // chr walks the columns and then two extra slots for CR and LF
  localparam int CHR_W  = $clog2(COLS + 2);
  localparam int BAUD_W = $clog2(BAUD_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SAMPLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [CHR_W-1:0]    chr_q, chr_d;
  logic [7:0]          byte_q, byte_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                dbg_q, dbg_d;
  logic                done_q, done_d;
  logic                baud_last;

  assign baud_last = (baud_q == BAUD_W'(BAUD_DIV - 1));

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      chr_q   <= '0;
      byte_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      dbg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      chr_q   <= chr_d;
      byte_q  <= byte_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      dbg_q   <= dbg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    chr_d   = chr_q;
    byte_d  = byte_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    dbg_d   = dbg_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // done_q marks the completion cycle; a start landing there is dropped
        if (start && !done_q) begin
          row_d   = 3'(ROWS - 1);
          chr_d   = '0;
          busy_d  = 1'b1;
          dbg_d   = 1'b1;
          state_d = S_ADDR;
        end
      end

      // address is already on the port; give the game top one cycle to return data
      S_ADDR: state_d = S_SAMPLE;

      S_SAMPLE: begin
        if (chr_q == CHR_W'(COLS)) begin
          byte_d = 8'h0D;
        end else if (chr_q == CHR_W'(COLS + 1)) begin
          byte_d = 8'h0A;
        end else begin
          case (d_piece_data)
            2'b00:   byte_d = 8'h2E;
            2'b01:   byte_d = 8'h31;
            2'b10:   byte_d = 8'h32;
            default: byte_d = 8'h3F;
          endcase
        end
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = S_TX_START;
      end

      S_TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = byte_q[0];
          state_d = S_TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      // byte_q is a shift register: bit 0 is always the bit on the line
      S_TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            byte_d = {1'b0, byte_q[7:1]};
            tx_d   = byte_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_TX_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_NEXT;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_NEXT: begin
        if (chr_q != CHR_W'(COLS + 1)) begin
          chr_d   = chr_q + CHR_W'(1);
          state_d = S_ADDR;
        end else if (row_q != 3'd0) begin
          row_d   = row_q - 3'd1;
          chr_d   = '0;
          state_d = S_ADDR;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dbg_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign e_debug    = dbg_q;
  assign read_board = dbg_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign uart_tx    = tx_q;
  // address parks at 0 when idle; CR/LF slots reuse column 0
  assign d_r_row    = busy_q ? row_q : 3'd0;
  assign d_r_col    = (busy_q && (chr_q < CHR_W'(COLS))) ? 3'(chr_q) : 3'd0;

endmodule

// File: tb/tb_board_dump_uart_tx.sv
// Purpose : randomized board dumps decoded by a bit-level UART receiver and compared to a text model.
// Latency : n/a (bench).
// Backpressure: n/a (bench); a reduced BAUD_DIV keeps run time short.
module tb_board_dump_uart_tx;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int BAUD = 11;
  localparam int NBYTES = ROWS * (COLS + 2);

  logic       clk_25MHz;
  logic       rst_n;
  logic       start;
  logic [1:0] d_piece_data;
  logic       e_debug, read_board, uart_tx, busy, done;
  logic [2:0] d_r_row, d_r_col;

  logic [1:0] model [0:ROWS-1][0:COLS-1];
  logic [7:0] exp_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         done_cnt = 0;

  board_dump_uart_tx #(.ROWS(ROWS), .COLS(COLS), .BAUD_DIV(BAUD)) dut (
    .clk_25MHz    (clk_25MHz),
    .rst_n        (rst_n),
    .start        (start),
    .d_piece_data (d_piece_data),
    .e_debug      (e_debug),
    .read_board   (read_board),
    .d_r_row      (d_r_row),
    .d_r_col      (d_r_col),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .done         (done)
  );

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  // game top stand-in: returns the modelled piece at the requested cell
  assign d_piece_data = model[d_r_row][d_r_col];

  always @(negedge clk_25MHz) if (done === 1'b1) done_cnt++;

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] piece_char(input logic [1:0] p);
    case (p)
      2'b00:   return 8'h2E;
      2'b01:   return 8'h31;
      2'b10:   return 8'h32;
      default: return 8'h3F;
    endcase
  endfunction

  // expected text: top row first, each row followed by CR LF
  task automatic build_expected();
    exp_q.delete();
    for (int r = ROWS - 1; r >= 0; r--) begin
      for (int c = 0; c < COLS; c++) exp_q.push_back(piece_char(model[r][c]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic randomize_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 2'($urandom_range(0, 3));
  endtask

  // waits for the line to go low; highs = idle-high samples seen first
  task automatic wait_fall(input int limit, output int highs, output bit found);
    found = 1'b0;
    highs = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_25MHz);
      if (uart_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      highs++;
    end
  endtask

  // called on the first low sample; checks every clock of the 10-bit frame
  task automatic rx_frame(input logic [7:0] exp_b, input int poke_at);
    int         bad;
    int         k;
    logic [7:0] dec;
    logic       want;
    bad = 0;
    dec = 8'h00;
    for (int s = 0; s < 10 * BAUD; s++) begin
      if (s > 0) @(negedge clk_25MHz);
      if (s == poke_at) start = 1'b1;
      else if (s == poke_at + 1) start = 1'b0;
      k = s / BAUD;
      if (k == 0) want = 1'b0;
      else if (k == 9) want = 1'b1;
      else want = exp_b[k-1];
      if (uart_tx !== want) bad++;
      if ((s % BAUD) == (BAUD / 2) && k >= 1 && k <= 8) dec[k-1] = uart_tx;
    end
    check_eq("frame_timing", 32'(bad), 32'd0);
    check_eq("byte", {24'd0, dec}, {24'd0, exp_b});
  endtask

  task automatic pulse_start();
    @(negedge clk_25MHz);
    start = 1'b1;
    @(negedge clk_25MHz);
    start = 1'b0;
  endtask

  task automatic do_dump(input int poke_byte, input bit start_at_done);
    int highs;
    bit found;
    int d0;
    int lows;
    build_expected();
    check_eq("exp_len", 32'(exp_q.size()), 32'(NBYTES));
    d0 = done_cnt;
    pulse_start();
    check_eq("busy_on", {31'd0, busy}, 32'd1);
    check_eq("e_debug_on", {31'd0, e_debug}, 32'd1);
    check_eq("read_board_on", {31'd0, read_board}, 32'd1);
    for (int i = 0; i < NBYTES; i++) begin
      wait_fall((i == 0) ? 20 : 4 * BAUD, highs, found);
      check_eq("tx_fall", {31'd0, found}, 32'd1);
      if (!found) return;
      if (i > 0) check_eq("gap", 32'(highs), 32'd3);
      rx_frame(exp_q[i], (i == poke_byte) ? 3 * BAUD : -10);
      if (i == NBYTES / 2) check_eq("busy_mid", {31'd0, busy}, 32'd1);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25MHz);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("done_seen", {31'd0, found}, 32'd1);
    if (start_at_done) begin
      start = 1'b1;
      @(negedge clk_25MHz);
      start = 1'b0;
    end
    lows = 0;
    for (int i = 0; i < 3 * BAUD; i++) begin
      @(negedge clk_25MHz);
      if (uart_tx !== 1'b1) lows++;
    end
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("busy_off", {31'd0, busy}, 32'd0);
    check_eq("e_debug_off", {31'd0, e_debug}, 32'd0);
    check_eq("read_board_off", {31'd0, read_board}, 32'd0);
    check_eq("idle_line", 32'(lows), 32'd0);
  endtask

  initial begin
    int  highs;
    bit  found;
    int  lows;
    int  d0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 2'b00;

    // reset state
    repeat (3) @(negedge clk_25MHz);
    check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_e_debug", {31'd0, e_debug}, 32'd0);
    check_eq("rst_read_board", {31'd0, read_board}, 32'd0);
    check_eq("rst_row", {29'd0, d_r_row}, 32'd0);
    check_eq("rst_col", {29'd0, d_r_col}, 32'd0);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25MHz);
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check_eq("post_rst_idle", 32'(lows), 32'd0);

    // empty board; start landing on the done cycle must be dropped
    do_dump(-1, 1'b1);

    // corner pieces on otherwise empty top and bottom rows, random middle
    randomize_board();
    for (int c = 0; c < COLS; c++) begin
      model[ROWS-1][c] = 2'b00;
      model[0][c]      = 2'b00;
    end
    model[0][3]      = 2'b01;
    model[ROWS-1][0] = 2'b10;
    do_dump(-1, 1'b0);

    // random board with a second start pulse in the middle of a byte
    randomize_board();
    do_dump(37, 1'b0);

    // reset during data bit 0 of byte index 4 ('.' keeps that bit low)
    randomize_board();
    model[ROWS-1][4] = 2'b00;
    build_expected();
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_fall((i == 0) ? 20 : 4 * BAUD, highs, found);
      check_eq("rst_run_fall", {31'd0, found}, 32'd1);
      if (found) rx_frame(exp_q[i], -10);
    end
    wait_fall(4 * BAUD, highs, found);
    check_eq("rst_run_fall5", {31'd0, found}, 32'd1);
    for (int i = 0; i < BAUD + BAUD / 2; i++) @(negedge clk_25MHz);
    check_eq("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_e_debug", {31'd0, e_debug}, 32'd0);
    check_eq("mid_rst_read_board", {31'd0, read_board}, 32'd0);
    repeat (4) @(negedge clk_25MHz);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_25MHz);
    check_eq("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("mid_rst_idle_busy", {31'd0, busy}, 32'd0);

    // full dump after the aborted one
    randomize_board();
    do_dump(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
